// File: rtl/digit_bounce_gen_pkg.sv
// rtl/digit_bounce_gen_pkg.sv - shared motion types and direction constants
//
// Package digit_motion_pkg
//   motion_state_t : FWD, REV and the two dwell states (used only when
//                    DIGIT_BOUNCE_DWELL_EN is defined)
//   DIR_FWD/DIR_REV: encoding of the dir output
package digit_motion_pkg;

  typedef enum logic [1:0] {
    FWD      = 2'd0,
    REV      = 2'd1,
    DWELL_HI = 2'd2,
    DWELL_LO = 2'd3
  } motion_state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

endpackage

// File: rtl/digit_bounce_gen_if.sv
// rtl/digit_bounce_gen_if.sv - control/position bundle of the bounce generator
//
// Signals
//   en      : level, motion runs while high
//   restart : one-cycle pulse, return to LOWER moving forward
//   coord   : COORD_W-bit digit x position
//   dir     : 1 = increasing, 0 = decreasing
//   tick    : one-cycle pulse on every step
//   at_edge : one-cycle pulse on the step that lands on a bound
// Modports
//   master : the controlling side (drives en/restart)
//   slave  : the generator
interface digit_bounce_gen_if #(
  parameter int COORD_W = 7
);

  logic               en;
  logic               restart;
  logic [COORD_W-1:0] coord;
  logic               dir;
  logic               tick;
  logic               at_edge;

  modport master (
    output en, restart,
    input  coord, dir, tick, at_edge
  );

  modport slave (
    input  en, restart,
    output coord, dir, tick, at_edge
  );

endinterface

// File: rtl/digit_bounce_gen_step_tick_gen.sv
// rtl/digit_bounce_gen_step_tick_gen.sv - enable-gated clock divider producing a step strobe
//
// Ports
//   clk   : system clock
//   rst_n : synchronous reset, active-low
//   en    : count only while high
//   clr   : clear the count; suppresses step in the same cycle
//   step  : combinational one-cycle strobe, high in the cycle whose edge
//           consumes count CLK_DIV-1 so the consumer registers its update
//           on that same edge
module step_tick_gen #(
  parameter int CLK_DIV = 1800000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int           CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q;

  assign step = en & ~clr & (div_cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else if (clr) begin
      div_cnt_q <= '0;
    end else if (en) begin
      div_cnt_q <= (div_cnt_q == LAST) ? '0 : div_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/digit_bounce_gen.sv
// rtl/digit_bounce_gen.sv - bouncing horizontal base coordinate for the digit renderer
//
// Moves coord between LOWER and UPPER one unit per step (CLK_DIV enabled
// clocks), reversing at each bound. Optional feature macro
// DIGIT_BOUNCE_DWELL_EN holds coord at each bound for DWELL_TICKS steps
// before reversing.
//
// Ports
//   clk   : system clock
//   rst_n : synchronous reset, active-low
//   bus   : digit_bounce_gen_if.slave (en, restart in; coord, dir, tick,
//           at_edge out, all outputs registered)
module digit_bounce_gen
  import digit_motion_pkg::*;
#(
  parameter int CLK_DIV     = 1800000,
  parameter int LOWER       = 0,
  parameter int UPPER       = 80,
  parameter int COORD_W     = 7,
  parameter int DWELL_TICKS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  digit_bounce_gen_if.slave bus
);

  localparam logic [COORD_W-1:0] LO_C = COORD_W'(LOWER);
  localparam logic [COORD_W-1:0] HI_C = COORD_W'(UPPER);
  // Degenerate range: coord is pinned, only tick keeps running.
  localparam bit FLAT = (LOWER == UPPER);

  if (CLK_DIV < 2 || UPPER < LOWER || UPPER >= (2 ** COORD_W) || DWELL_TICKS < 1)
  begin : g_cfg_check
    $error("digit_bounce_gen: illegal parameter set");
  end

  logic               step;
  motion_state_t      state_q;
  logic [COORD_W-1:0] coord_q;
  logic               dir_q;
  logic               tick_q;
  logic               at_edge_q;
  logic [COORD_W-1:0] coord_up_d;
  logic [COORD_W-1:0] coord_dn_d;

`ifdef DIGIT_BOUNCE_DWELL_EN
  localparam int DW_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_TICKS - 1);
  logic [DW_W-1:0] dwell_q;
`endif

  step_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_step (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .clr   (bus.restart),
    .step  (step)
  );

  assign coord_up_d = coord_q + 1'b1;
  assign coord_dn_d = coord_q - 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FWD;
      coord_q   <= LO_C;
      dir_q     <= DIR_FWD;
      tick_q    <= 1'b0;
      at_edge_q <= 1'b0;
`ifdef DIGIT_BOUNCE_DWELL_EN
      dwell_q   <= '0;
`endif
    end else begin
      tick_q    <= 1'b0;
      at_edge_q <= 1'b0;
      if (bus.restart) begin
        state_q <= FWD;
        coord_q <= LO_C;
        dir_q   <= DIR_FWD;
`ifdef DIGIT_BOUNCE_DWELL_EN
        dwell_q <= '0;
`endif
      end else if (step) begin
        tick_q <= 1'b1;
        case (state_q)
          FWD: begin
            if (!FLAT) begin
              coord_q <= coord_up_d;
              if (coord_up_d == HI_C) begin
                at_edge_q <= 1'b1;
                dir_q     <= DIR_REV;
`ifdef DIGIT_BOUNCE_DWELL_EN
                state_q   <= DWELL_HI;
`else
                state_q   <= REV;
`endif
              end
            end
          end
          REV: begin
            coord_q <= coord_dn_d;
            if (coord_dn_d == LO_C) begin
              at_edge_q <= 1'b1;
              dir_q     <= DIR_FWD;
`ifdef DIGIT_BOUNCE_DWELL_EN
              state_q   <= DWELL_LO;
`else
              state_q   <= FWD;
`endif
            end
          end
`ifdef DIGIT_BOUNCE_DWELL_EN
          // Held steps: coord and dir already reflect the bound reached.
          DWELL_HI: begin
            if (dwell_q == DW_LAST) begin
              dwell_q <= '0;
              state_q <= REV;
            end else begin
              dwell_q <= dwell_q + 1'b1;
            end
          end
          DWELL_LO: begin
            if (dwell_q == DW_LAST) begin
              dwell_q <= '0;
              state_q <= FWD;
            end else begin
              dwell_q <= dwell_q + 1'b1;
            end
          end
`endif
          default: begin
            state_q <= FWD;
            dir_q   <= DIR_FWD;
          end
        endcase
      end
    end
  end

  assign bus.coord   = coord_q;
  assign bus.dir     = dir_q;
  assign bus.tick    = tick_q;
  assign bus.at_edge = at_edge_q;

endmodule

// File: tb/tb_digit_bounce_gen.sv
// tb/tb_digit_bounce_gen.sv - directed self-checking bench for digit_bounce_gen
module tb_digit_bounce_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic restart = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  digit_bounce_gen_if #(.COORD_W(7)) if_a ();
  digit_bounce_gen_if #(.COORD_W(7)) if_b ();

  assign if_a.en      = en;
  assign if_a.restart = restart;
  assign if_b.en      = en;
  assign if_b.restart = restart;

  digit_bounce_gen #(
    .CLK_DIV (4), .LOWER (0), .UPPER (3), .COORD_W (7), .DWELL_TICKS (2)
  ) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (if_a)
  );

  digit_bounce_gen #(
    .CLK_DIV (4), .LOWER (5), .UPPER (5), .COORD_W (7), .DWELL_TICKS (2)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (if_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Check all four outputs of dut_a plus the pinned dut_b.
  task automatic check_state(input string tag, input int c, input int d, input int t, input int e);
    check_eq({tag, "_coord"}, 32'(if_a.coord), c);
    check_eq({tag, "_dir"}, 32'(if_a.dir), d);
    check_eq({tag, "_tick"}, 32'(if_a.tick), t);
    check_eq({tag, "_edge"}, 32'(if_a.at_edge), e);
    check_eq({tag, "_b_coord"}, 32'(if_b.coord), 5);
    check_eq({tag, "_b_tick"}, 32'(if_b.tick), t);
    check_eq({tag, "_b_edge"}, 32'(if_b.at_edge), 0);
  endtask

  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq({tag, "_tick"}, 32'(if_a.tick), 0);
      check_eq({tag, "_edge"}, 32'(if_a.at_edge), 0);
      check_eq({tag, "_b_tick"}, 32'(if_b.tick), 0);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int exp_c [8];
    int exp_d [8];
    int exp_e [8];
    int cur_c, cur_d, t, e;
    int frz_c, frz_d;
    int r1_c, r1_d, r1_e, r2_c, r2_d;

`ifdef DIGIT_BOUNCE_DWELL_EN
    exp_c = '{1, 2, 3, 3, 3, 2, 1, 0};
    exp_d = '{1, 1, 0, 0, 0, 0, 0, 1};
    exp_e = '{0, 0, 1, 0, 0, 0, 0, 1};
    frz_c = 0; frz_d = 1;
    r1_c = 0; r1_d = 1; r1_e = 0;
    r2_c = 0; r2_d = 1;
`else
    exp_c = '{1, 2, 3, 2, 1, 0, 1, 2};
    exp_d = '{1, 1, 0, 0, 0, 1, 1, 1};
    exp_e = '{0, 0, 1, 0, 0, 1, 0, 0};
    frz_c = 2; frz_d = 1;
    r1_c = 3; r1_d = 0; r1_e = 1;
    r2_c = 2; r2_d = 0;
`endif

    // Reset values
    repeat (2) @(negedge clk);
    check_state("rst", 0, 1, 0, 0);
    rst_n = 1'b1;

    // Free-running bounce, tick every 4 cycles
    cur_c = 0;
    cur_d = 1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k % 4 == 0) begin
        cur_c = exp_c[k / 4 - 1];
        cur_d = exp_d[k / 4 - 1];
        e = exp_e[k / 4 - 1];
        t = 1;
      end else begin
        e = 0;
        t = 0;
      end
      check_state($sformatf("run%0d", k), cur_c, cur_d, t, e);
    end

    // Freeze with en low mid-count (count is 2 after two more cycles)
    quiet("pre_frz", 2);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_state("frz", frz_c, frz_d, 0, 0);
    end
    en = 1'b1;
    quiet("resume", 1);
    @(negedge clk);
    check_state("resume_step", r1_c, r1_d, 1, r1_e);

    // Restart coincident with a step
    quiet("pre_rs", 3);
    @(negedge clk);
    check_state("rs_prev_step", r2_c, r2_d, 1, 0);
    quiet("pre_rs2", 3);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check_state("rs", 0, 1, 0, 0);
    quiet("post_rs", 3);
    @(negedge clk);
    check_state("rs_step", 1, 1, 1, 0);

    // Reset mid-motion at coord 2
    quiet("pre_mr", 3);
    @(negedge clk);
    check_state("mr_c2", 2, 1, 1, 0);
    quiet("pre_mr2", 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_state("mr", 0, 1, 0, 0);
    quiet("post_mr", 3);
    @(negedge clk);
    check_state("mr_step", 1, 1, 1, 0);

    // Restart while disabled must still clear the divider
    quiet("pre_rd", 2);
    en = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    en = 1'b1;
    check_state("rd", 0, 1, 0, 0);
    quiet("post_rd", 3);
    @(negedge clk);
    check_state("rd_step", 1, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
